// File: rtl/iq_boxcar_decimator_if.sv
// 12-bit signed I/Q sample stream with a valid/ready handshake.
// The master drives the sample and valid; the slave returns ready.
interface iq_boxcar_decimator_if;
    logic signed [11:0] i;
    logic signed [11:0] q;
    logic               valid;
    logic               ready;

    modport master (output i, output q, output valid, input ready);
    modport slave  (input i, input q, input valid, output ready);
endinterface

// File: rtl/iq_boxcar_decimator.sv
// Complex boxcar-average decimator: averages each block of DECIMATION accepted I/Q samples
// into one output pair, with a floor (arithmetic-shift) divide and valid/ready on both sides.
module iq_boxcar_decimator #(
    parameter int unsigned  LOG2_DECIMATION = 3,
    localparam int unsigned DECIMATION      = 2 ** LOG2_DECIMATION
) (
    input  logic                  clk,
    input  logic                  rst,
    iq_boxcar_decimator_if.slave  up,
    iq_boxcar_decimator_if.master dn
);

    localparam int unsigned     AccW    = 12 + LOG2_DECIMATION;
    localparam int unsigned     CntW    = LOG2_DECIMATION;
    localparam logic [CntW-1:0] CntLast = CntW'(DECIMATION - 1);

    logic [CntW-1:0]        count_q, count_d;
    logic signed [AccW-1:0] acc_i_q, acc_i_d;
    logic signed [AccW-1:0] acc_q_q, acc_q_d;
    logic signed [11:0]     out_i_q, out_i_d;
    logic signed [11:0]     out_q_q, out_q_d;
    logic                   out_valid_q, out_valid_d;

    logic                   accept;
    logic                   last;
    logic signed [AccW-1:0] sum_i;
    logic signed [AccW-1:0] sum_q;

    assign last = (count_q == CntLast);

    // Only the block-completing sample stalls on a held result; in_ready sees out_ready
    // combinationally so a same-cycle drain lets the completion through without a bubble.
    assign up.ready = !(out_valid_q && !dn.ready && last);
    assign accept   = up.valid && up.ready;

    assign sum_i = acc_i_q + $signed({{LOG2_DECIMATION{up.i[11]}}, up.i});
    assign sum_q = acc_q_q + $signed({{LOG2_DECIMATION{up.q[11]}}, up.q});

    always_comb begin
        count_d     = count_q;
        acc_i_d     = acc_i_q;
        acc_q_d     = acc_q_q;
        out_i_d     = out_i_q;
        out_q_d     = out_q_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && dn.ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (last) begin
                // Full-precision sum always fits 12 bits after the shift; floor rounding.
                out_i_d     = 12'(sum_i >>> LOG2_DECIMATION);
                out_q_d     = 12'(sum_q >>> LOG2_DECIMATION);
                out_valid_d = 1'b1;
                acc_i_d     = '0;
                acc_q_d     = '0;
                count_d     = '0;
            end else begin
                acc_i_d = sum_i;
                acc_q_d = sum_q;
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q     <= '0;
            acc_i_q     <= '0;
            acc_q_q     <= '0;
            out_i_q     <= '0;
            out_q_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            acc_i_q     <= acc_i_d;
            acc_q_q     <= acc_q_d;
            out_i_q     <= out_i_d;
            out_q_q     <= out_q_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign dn.i     = out_i_q;
    assign dn.q     = out_q_q;
    assign dn.valid = out_valid_q;

endmodule

// File: tb/tb_iq_boxcar_decimator.sv
// Self-checking bench for iq_boxcar_decimator: block-vector table plus hand-written
// reset, backpressure and gap sequences, all checked through a result scoreboard.
module tb_iq_boxcar_decimator;

    localparam int Log2Dec = 3;
    localparam int Dec     = 8;

    typedef struct {
        int i;
        int q;
    } pair_t;

    typedef struct {
        logic [7:0][11:0] si;
        logic [7:0][11:0] sq;
        int               exp_i;
        int               exp_q;
    } vec_t;

    logic clk;
    logic rst;

    iq_boxcar_decimator_if up ();
    iq_boxcar_decimator_if dn ();

    iq_boxcar_decimator #(
        .LOG2_DECIMATION(Log2Dec)
    ) dut (
        .clk(clk),
        .rst(rst),
        .up (up),
        .dn (dn)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int    checks;
    int    errors;
    pair_t exp_q[$];
    pair_t last_out;
    int    m_count;
    int    m_sum_i;
    int    m_sum_q;
    bit    tbl_mode;
    int    tbl_i;
    int    tbl_q;
    int    dut_pulses;
    vec_t  tv[6];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    function automatic int floor_avg(input int s);
        if (s >= 0) return s / Dec;
        return -((-s + Dec - 1) / Dec);
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        last_out.i = 0;
        last_out.q = 0;
        m_count    = 0;
        m_sum_i    = 0;
        m_sum_q    = 0;
    endfunction

    // One clock: drive at the falling edge, check 1 ns later, update the model at the rising edge.
    task automatic cycle(input logic v, input logic signed [11:0] si,
                         input logic signed [11:0] sq, input logic rdy);
        bit    pend;
        bit    m_rdy;
        pair_t p;
        @(negedge clk);
        up.valid = v;
        up.i     = si;
        up.q     = sq;
        dn.ready = rdy;
        #1;
        pend  = (exp_q.size() > 0);
        m_rdy = !(pend && !rdy && (m_count == Dec - 1));
        chk("in_ready", int'(up.ready), int'(m_rdy));
        chk("out_valid", int'(dn.valid), int'(pend));
        if (pend) begin
            chk("out_i", dn.i, exp_q[0].i);
            chk("out_q", dn.q, exp_q[0].q);
        end else begin
            chk("out_i_hold", dn.i, last_out.i);
            chk("out_q_hold", dn.q, last_out.q);
        end
        if (dn.valid && rdy) dut_pulses++;
        @(posedge clk);
        if (pend && rdy) begin
            last_out = exp_q[0];
            exp_q.pop_front();
        end
        if (v && m_rdy) begin
            m_sum_i += si;
            m_sum_q += sq;
            if (m_count == Dec - 1) begin
                if (tbl_mode) begin
                    p.i = tbl_i;
                    p.q = tbl_q;
                end else begin
                    p.i = floor_avg(m_sum_i);
                    p.q = floor_avg(m_sum_q);
                end
                exp_q.push_back(p);
                m_sum_i = 0;
                m_sum_q = 0;
                m_count = 0;
            end else begin
                m_count++;
            end
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        tbl_mode   = 1'b0;
        tbl_i      = 0;
        tbl_q      = 0;
        dut_pulses = 0;
        model_reset();
        rst      = 1'b0;
        dn.ready = 1'b1;

        tv[0].si = {8{12'd100}};         tv[0].sq = {8{12'hF9C}};
        tv[0].exp_i = 100;               tv[0].exp_q = -100;
        tv[1].si = {8{12'd0}};           tv[1].sq = {8{12'd0}};
        tv[1].exp_i = 0;                 tv[1].exp_q = 0;
        tv[2].si = {12'hFFF, {7{12'h000}}};
        tv[2].sq = {12'h000, {7{12'h001}}};
        tv[2].exp_i = -1;                tv[2].exp_q = 0;
        tv[3].si = {8{12'h7FF}};         tv[3].sq = {8{12'h800}};
        tv[3].exp_i = 2047;              tv[3].exp_q = -2048;
        tv[4].si = {12'd8, 12'd7, 12'd6, 12'd5, 12'd4, 12'd3, 12'd2, 12'd1};
        tv[4].sq = {12'hFF8, 12'hFF9, 12'hFFA, 12'hFFB, 12'hFFC, 12'hFFD, 12'hFFE, 12'hFFF};
        tv[4].exp_i = 4;                 tv[4].exp_q = -5;
        tv[5].si = {12'hFFD, {7{12'h000}}};
        tv[5].sq = {12'h800, {7{12'h7FF}}};
        tv[5].exp_i = -1;                tv[5].exp_q = 1535;

        // Long reset with live input: nothing may move.
        up.valid = 1'b1;
        up.i     = 12'hAAA;
        up.q     = 12'h0F0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            #1;
            chk("rst_out_i", dn.i, 0);
            chk("rst_out_q", dn.q, 0);
            chk("rst_out_valid", int'(dn.valid), 0);
            chk("rst_in_ready", int'(up.ready), 1);
        end
        up.valid = 1'b0;
        rst      = 1'b1;

        // Build a pending result, then reset asynchronously mid-cycle.
        for (int c = 0; c < 8; c++) cycle(1'b1, 12'sd3, -12'sd3, 1'b0);
        @(negedge clk);
        #2;
        chk("pend_valid_before_rst", int'(dn.valid), 1);
        up.valid = 1'b0;
        rst      = 1'b0;
        #1;
        chk("async_rst_out_valid", int'(dn.valid), 0);
        chk("async_rst_in_ready", int'(up.ready), 1);
        chk("async_rst_out_i", dn.i, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        // Back-to-back blocks from the vector table.
        tbl_mode   = 1'b1;
        dut_pulses = 0;
        for (int k = 0; k < 6; k++) begin
            tbl_i = tv[k].exp_i;
            tbl_q = tv[k].exp_q;
            for (int j = 0; j < Dec; j++) cycle(1'b1, tv[k].si[j], tv[k].sq[j], 1'b1);
        end
        cycle(1'b0, 12'sd0, 12'sd0, 1'b1);
        chk("table_pulses", dut_pulses, 6);
        tbl_mode = 1'b0;

        // Backpressure: first result held, 7 more accepted, then the completing sample stalls.
        for (int c = 0; c < 15; c++) cycle(1'b1, 12'sd5, 12'sd5, 1'b0);
        for (int c = 0; c < 20; c++) cycle(1'b1, 12'sd5, 12'sd5, 1'b0);
        cycle(1'b1, 12'sd5, 12'sd5, 1'b1);
        cycle(1'b0, 12'sd0, 12'sd0, 1'b1);
        cycle(1'b0, 12'sd0, 12'sd0, 1'b1);

        // Sparse input: 1 on, 2 off.
        tbl_mode   = 1'b1;
        tbl_i      = 4;
        tbl_q      = -5;
        dut_pulses = 0;
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b1, 12'(k), 12'(-k), 1'b1);
            cycle(1'b0, 12'sd0, 12'sd0, 1'b1);
            cycle(1'b0, 12'sd0, 12'sd0, 1'b1);
        end
        chk("gap_pulses", dut_pulses, 1);
        tbl_mode = 1'b0;

        // Reset in the middle of a block discards the partial sum.
        for (int c = 0; c < 5; c++) cycle(1'b1, 12'sd1000, 12'sd1000, 1'b1);
        @(negedge clk);
        up.valid = 1'b0;
        rst      = 1'b0;
        #1;
        chk("midblk_rst_out_valid", int'(dn.valid), 0);
        model_reset();
        @(negedge clk);
        rst        = 1'b1;
        tbl_mode   = 1'b1;
        tbl_i      = 40;
        tbl_q      = 40;
        dut_pulses = 0;
        for (int c = 0; c < 8; c++) cycle(1'b1, 12'sd40, 12'sd40, 1'b1);
        cycle(1'b0, 12'sd0, 12'sd0, 1'b1);
        cycle(1'b0, 12'sd0, 12'sd0, 1'b1);
        chk("midblk_pulses", dut_pulses, 1);
        tbl_mode = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iq_boxcar_decimator.md
# iq_boxcar_decimator

Complex boxcar-average decimator that sits directly upstream of the frequency-locked loop. It averages each block of DECIMATION consecutive accepted I/Q samples and emits one averaged sample pair. This lowers the sample rate and raises SNR before carrier frequency recovery. Its output drives the loop's `in_i`/`in_q`/`in_valid` inputs and receives that stage's `in_ready` back, using the same 12-bit signed sample format and valid/ready handshake.

## Interface
- `LOG2_DECIMATION`, default 3: log2 of the decimation factor. Legal range 1..6.
- `DECIMATION`, default `2**LOG2_DECIMATION`: derived. Not to be overridden independently.
- `clk` input 1: the single clock. All state is updated on its rising edge.
- `rst` input 1: asynchronous, active-low reset. Asserted when 0; takes effect immediately, without waiting for `clk`.
- `in_i` input 12: signed two's-complement in-phase sample.
- `in_q` input 12: signed two's-complement quadrature sample.
- `in_valid` input 1: upstream sample present.
- `in_ready` output 1: block can accept a sample this cycle.
- `out_i` output 12: signed averaged in-phase result.
- `out_q` output 12: signed averaged quadrature result.
- `out_valid` output 1: `out_i`/`out_q` hold an unconsumed result.
- `out_ready` input 1: downstream accepts the result this cycle.

## Operation
- State:
  - `count`: sample index within the current block, 0..DECIMATION-1.
  - `acc_i`, `acc_q`: signed accumulators, each 12+LOG2_DECIMATION bits wide, so they never overflow.
  - Output register: `out_i`, `out_q`, `out_valid`.
- Reset values: `count`=0, both accumulators=0, `out_i`=0, `out_q`=0, `out_valid`=0. `in_ready`=1 while in reset, since it follows combinationally from the reset state.
- A sample is accepted on a rising edge where `in_valid && in_ready`. No state changes on cycles without an accepted sample; `count` advances only on accepted samples, so gaps in `in_valid` are transparent.
- Accepted sample with `count` < DECIMATION-1:
  - `acc += in` on each rail.
  - `count++`.
- Accepted sample with `count` == DECIMATION-1 (block completion):
  - `out_i` <= `(acc_i + in_i) >>> LOG2_DECIMATION`, and likewise for Q.
  - `out_valid` <= 1.
  - Accumulators <= 0, `count` <= 0.
- Arithmetic:
  - The sum is the full-precision signed sum.
  - The shift is arithmetic, so results round toward negative infinity (floor).
  - The result always fits in 12 bits.
  - There is no saturation logic and none is required.
- Result drain: on an edge with `out_valid && out_ready` and no block completion, `out_valid` <= 0. `out_i`/`out_q` keep their last value.
- Simultaneous drain and completion: the new result loads and `out_valid` stays 1. No bubble and no lost result.
- `in_ready` = `!(out_valid && !out_ready && count == DECIMATION-1)`.
  - Backpressure stalls only the sample that would complete a block.
  - Partial accumulation continues while the output is held.
  - `in_ready` depends combinationally on `out_ready`. This is permitted; the path is documented.
- While `out_valid && !out_ready`, `out_i`/`out_q` must remain stable.
- Reset asserted mid-block or with a result pending: all state returns to reset values immediately. The partial sum and any pending result are discarded.

## Timing
- Throughput: one input sample per cycle sustained when `out_ready` stays high.
- Latency: the result is registered on the edge that accepts the DECIMATION-th sample. `out_valid` and the data are visible in the following cycle, one cycle after that sample is presented.
- Output cadence with continuous input: one `out_valid` pulse every DECIMATION cycles. It stays high longer only under backpressure.
- Reset release: the first sample can be accepted on the first rising edge after `rst` returns to 1.

## Test plan
- **Reset:** hold `rst`=0 for 1000 cycles while driving `in_i`=12'hAAA, `in_q`=12'h0F0, `in_valid`=1.
  - Required: `out_i`=`out_q`=0, `out_valid`=0, `in_ready`=1 every cycle.
  - Then drop `rst` mid-cycle with a result pending: `out_valid` must go 0 before the next edge.
- **Constant and zero input, DECIMATION=8, `out_ready`=1:**
  - `in_i`=100, `in_q`=-100 continuously: `out_i`=100, `out_q`=-100, `out_valid` high for exactly 1 cycle of every 8, first asserted the cycle after the 8th accepted sample.
  - All-zero input: outputs 0 throughout.
- **Floor and full scale:**
  - Seven 0s then one -1 on I gives `out_i`=-1.
  - Sum +7 on Q gives `out_q`=0.
  - Eight samples of 2047 give 2047; eight samples of -2048 give -2048.
- **Backpressure:**
  - Setup: `out_ready`=0, continuous `in_valid` of value 5.
  - First result is held at 5; 7 further samples are accepted; `in_ready`=0 with `count`=7; outputs stay stable for 20 cycles.
  - Raise `out_ready`: `in_ready`=1 in the same cycle, and on the next edge the second result (5) loads with `out_valid` still 1.
- **Input gaps:** toggle `in_valid` in a 1-on/2-off pattern with values 1..8.
  - Required: exactly one result, `out_i` = 36 >>> 3 = 4, once 8 samples have been accepted.
- **Reset mid-block:** accept 5 samples of 1000, pulse `rst` low, then feed 8 samples of 40.
  - Required: the first result is 40; the partial sum of 1000s is discarded.
